logicnet_layer_gather_stage: RTL

// - Registered boundary between two LogicNet layers. Captures the packed output bits of layer N-1 and

---
 rtl/logicnet_pkg.sv | 32 +++
 rtl/logicnet_skid_buffer.sv | 75 +++++++
 rtl/logicnet_layer_gather_stage.sv | 66 ++++++
 3 files changed

// File: rtl/logicnet_pkg.sv
// Shared LogicNet constants: default neuron geometry, occupancy encodings and
// the connectivity-table lookup used by the layer gather stages.
package logicnet_pkg;

   localparam int unsigned FANIN       = 8;
   localparam int unsigned IDX_W       = 8;
   localparam int unsigned MAX_NEURONS = 256;
   localparam int unsigned CONN_MAX_W  = MAX_NEURONS * FANIN * IDX_W;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // Table entry [n][k] lives at bit offset (n*fanin+k)*idx_w of the flat table.
   function automatic int unsigned conn_idx(
      input logic [CONN_MAX_W-1:0] conn,
      input int unsigned           n,
      input int unsigned           k,
      input int unsigned           fanin,
      input int unsigned           idx_w
   );
      int unsigned idx;
      idx = 0;
      for (int unsigned b = 0; b < idx_w; b++) begin
         if (conn[(n * fanin + k) * idx_w + b]) begin
            idx = idx | (32'd1 << b);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/logicnet_skid_buffer.sv
// Generic 2-entry valid/ready buffer: head register drives the output, skid
// register holds the second sample so back-pressure never drops data.
module logicnet_skid_buffer
   import logicnet_pkg::*;
#(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic [1:0]   r_state;
   logic [1:0]   w_state_nxt;
   logic [W-1:0] r_head;
   logic [W-1:0] r_skid;
   logic         r_in_ready;
   logic         w_push;
   logic         w_pop;

   assign o_valid = (r_state != ST_EMPTY);
   assign o_ready = r_in_ready;
   assign o_data  = r_head;
   assign w_push  = i_valid & r_in_ready;
   assign w_pop   = o_valid & i_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_push) w_state_nxt = ST_ONE;
         end
         ST_ONE: begin
            if (w_push && !w_pop)      w_state_nxt = ST_FULL;
            else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
         end
         ST_FULL: begin
            if (w_pop) w_state_nxt = ST_ONE;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // Ready is registered from the next occupancy, so it never sees i_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_head     <= '0;
         r_skid     <= '0;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
         case (r_state)
            ST_EMPTY: begin
               if (w_push) r_head <= i_data;
            end
            ST_ONE: begin
               if (w_push && w_pop) r_head <= i_data;
               else if (w_push)     r_skid <= i_data;
            end
            ST_FULL: begin
               if (w_pop) r_head <= r_skid;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/logicnet_layer_gather_stage.sv
// Registered boundary between two LogicNet layers: gathers each neuron's fan-in
// bits through the fixed connectivity table, then buffers them behind valid/ready.
module logicnet_layer_gather_stage #(
   parameter int unsigned IN_WIDTH  = 256,
   parameter int unsigned N_NEURONS = 8,
   parameter int unsigned FANIN     = logicnet_pkg::FANIN,
   parameter int unsigned IDX_W     = logicnet_pkg::IDX_W,
   parameter logic [N_NEURONS*FANIN*IDX_W-1:0] CONN = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_WIDTH-1:0]        in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_NEURONS*FANIN-1:0] out_data,
   output logic [15:0]                out_count
);

   localparam int unsigned OUT_W      = N_NEURONS * FANIN;
   localparam int unsigned CONN_EXT_W = logicnet_pkg::CONN_MAX_W;
   localparam logic [CONN_EXT_W-1:0] CONN_EXT = CONN_EXT_W'(CONN);

   logic [OUT_W-1:0] w_gather;
   logic             w_unused_in;
   logic [15:0]      r_count;

   // Upstream bits not named by the table are intentionally dropped.
   assign w_unused_in = ^in_data;

   for (genvar gn = 0; gn < N_NEURONS; gn++) begin : g_neuron
      for (genvar gk = 0; gk < FANIN; gk++) begin : g_bit
         localparam int unsigned SRC = logicnet_pkg::conn_idx(CONN_EXT, gn, gk, FANIN, IDX_W);
         if (SRC < IN_WIDTH) begin : g_map
            assign w_gather[gn*FANIN+gk] = in_data[SRC];
         end else begin : g_tie
            assign w_gather[gn*FANIN+gk] = 1'b0;
         end
      end
   end

   logicnet_skid_buffer #(
      .W (OUT_W)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst),
      .i_valid (in_valid),
      .o_ready (in_ready),
      .i_data  (w_gather),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (out_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (out_valid && out_ready) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign out_count = r_count;

endmodule
